round_timer: RTL and testbench
==============================

# round_timer

Countdown timer for the guessing game's per-round time limit. Consumes the square-wave `slow_clk` produced by the clock divider and resynchronises it into the `clk_in` domain. It turns each rising edge into a one-cycle tick and counts a BCD seconds value down from a start value. Its BCD digits feed the seven-segment display driver, and its `timeout` pulse feeds the game controller, which ends the round.

## Interface
Parameters:
- `START_TENS`, default 3: tens digit of the round length, range 0–9.
- `START_ONES`, default 0: ones digit of the round length, range 0–9. `START_TENS:START_ONES` must be ≥ 01.
- `WARN_SECS`, default 5: binary threshold at or below which `warn` asserts while running.

Ports (the block uses reset `rst`, asynchronous, active-high, and clock `clk_in`):
- `clk_in`  in  1: system clock.
- `rst`  in  1: asynchronous active-high reset.
- `slow_clk`  in  1: divided clock from the clock divider, asynchronous to this logic.
- `start`  in  1: one-cycle pulse; (re)loads the start value and runs.
- `stop`  in  1: one-cycle pulse; freezes the count and returns to IDLE (player guessed).
- `pause`  in  1: one-cycle pulse; toggles RUN ↔ PAUSE.
- `tens`  out  4: BCD tens digit of the remaining time.
- `ones`  out  4: BCD ones digit of the remaining time.
- `running`  out  1: high in RUN.
- `paused`  out  1: high in PAUSE.
- `expired`  out  1: high in EXPIRED.
- `timeout`  out  1: one-cycle pulse on entry to EXPIRED.
- `warn`  out  1: high when in RUN and the remaining time ≤ `WARN_SECS`.

## Operation
- **Synchroniser.** `slow_clk` passes through two flops (`s1`, `s2`) and a history flop `s3`. `tick = s2 & ~s3`, registered.
- **States** (registered): IDLE, RUN, PAUSE, EXPIRED.
  - IDLE: `start` → RUN and load START. Ticks, `pause` and `stop` are ignored. The count holds its value.
  - RUN: `stop` → IDLE with the count frozen. Otherwise `start` reloads START and stays in RUN. Otherwise `pause` → PAUSE. Otherwise a tick decrements the count.
    - A tick when the count is 01 → count 00, state EXPIRED, `timeout` = 1 for one cycle.
  - PAUSE: `stop` → IDLE. Otherwise `start` → RUN with reload. Otherwise `pause` → RUN. Ticks are ignored; a tick is not deferred.
  - EXPIRED: the count holds 00. `start` → RUN with reload. `stop` → IDLE. `pause` is ignored.
- **Priority** within one cycle: `stop` > `start` > `pause` > tick. A tick coincident with any accepted control pulse is discarded.
- **BCD decrement.**
  - If `ones` ≠ 0, `ones`−1.
  - Otherwise `ones` = 9 and `tens`−1.
  - The count never goes below 00 and never wraps to 99.
- **`warn`.** Combinational compare of `tens*10+ones ≤ WARN_SECS`, gated by RUN, then registered.

## Timing
- **Reset values.**
  - State IDLE.
  - `tens` = `START_TENS`, `ones` = `START_ONES`.
  - `s1`, `s2`, `s3`, `tick` = 0.
  - `running`, `paused`, `expired`, `timeout`, `warn` = 0.
- **Input to tick.** A `slow_clk` rising edge produces `tick` 3–4 `clk_in` edges later; the count changes on the following edge.
- **Exactly one tick per `slow_clk` rising edge.** Falling edges produce no tick.
- **Post-reset spurious tick.** If `slow_clk` is high when `rst` releases, one tick may occur. It is harmless because the block is in IDLE.
- **Control latency.** A control pulse at edge N changes the state and outputs at edge N+1. Every output is registered.
- **`timeout` timing.** `timeout` is high in the same cycle the count shows 00 and `expired` first rises.
- **Mid-operation reset.** `rst` asserted mid-round returns everything to the reset values immediately; no `timeout` is produced.

## Structure
- **Shared package `game_pkg`:**
  - state enum `timer_state_t` (IDLE, RUN, PAUSE, EXPIRED, 2 bits);
  - `BCD_W` = 4;
  - default round-length constants.
- **Sub-module `edge_sync`:** 2-flop synchroniser plus rising-edge detector, with ports `clk_in`, `rst`, `async_in`, `rise_pulse`. Reused for button inputs elsewhere.
- **Top-level contents:** the FSM, the BCD counter and the output registers.

## Test plan
- **Reset and idle.** Reset, then toggle `slow_clk` 5 periods with no `start` → `tens:ones` = 3:0, all flags 0, no `timeout`.
- **Normal decrement.** `start`, then 3 `slow_clk` rising edges → 2:7. `warn` = 0 until 0:5, then 1.
- **Expiry.** Set `START` = 0:2, `start`, then 2 edges → count 0:0, `timeout` high exactly one cycle, `expired` = 1. Further edges keep 0:0.
- **Ones-to-tens borrow.** Count at 1:0, one edge → 0:9. Check the borrow with no intermediate glitch values.
- **Pause.** `pause` at 2:5, 4 edges → count stays 2:5 and `paused` = 1. `pause` again, then 1 edge → 2:4.
- **Simultaneous events and reset.**
  - `stop` and a tick in the same cycle at 1:3 → IDLE holding 1:3.
  - `start` in EXPIRED → RUN, 3:0.
  - `rst` mid-round → reset values, no `timeout`.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the guessing-game blocks.
package game_pkg;

    localparam int unsigned BCD_W          = 4;
    localparam int unsigned DEF_START_TENS = 3;
    localparam int unsigned DEF_START_ONES = 0;
    localparam int unsigned DEF_WARN_SECS  = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser with a registered rising-edge pulse output.
module edge_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic s1;
    logic s2;
    logic s3;

    // Resynchronise the async input and flag a rising edge for one cycle.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            s1         <= async_in;
            s2         <= s1;
            s3         <= s2;
            rise_pulse <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/round_timer.sv
// Per-round BCD countdown timer driven by ticks from the divided slow clock.
module round_timer
    import game_pkg::*;
#(
    parameter int unsigned START_TENS = DEF_START_TENS,
    parameter int unsigned START_ONES = DEF_START_ONES,
    parameter int unsigned WARN_SECS  = DEF_WARN_SECS
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             running,
    output logic             paused,
    output logic             expired,
    output logic             timeout,
    output logic             warn
);

    localparam int unsigned     SECS_W    = 7;
    localparam logic [BCD_W-1:0] LOAD_TENS = BCD_W'(START_TENS);
    localparam logic [BCD_W-1:0] LOAD_ONES = BCD_W'(START_ONES);

    timer_state_t      state;
    timer_state_t      state_nxt;
    logic [BCD_W-1:0]  tens_nxt;
    logic [BCD_W-1:0]  ones_nxt;
    logic [SECS_W-1:0] secs_nxt;
    logic              timeout_nxt;
    logic              warn_nxt;
    logic              tick;

    edge_sync u_sync (
        .clk_in     (clk_in),
        .rst        (rst),
        .async_in   (slow_clk),
        .rise_pulse (tick)
    );

    // State register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and count: stop > start > pause > tick.
    always_comb begin
        state_nxt   = state;
        tens_nxt    = tens;
        ones_nxt    = ones;
        timeout_nxt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    tens_nxt  = LOAD_TENS;
                    ones_nxt  = LOAD_ONES;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    tens_nxt = LOAD_TENS;
                    ones_nxt = LOAD_ONES;
                end else if (pause) begin
                    state_nxt = ST_PAUSE;
                end else if (tick) begin
                    if (tens == '0 && ones == BCD_W'(1)) begin
                        ones_nxt    = '0;
                        state_nxt   = ST_EXPIRED;
                        timeout_nxt = 1'b1;
                    end else if (ones != '0) begin
                        ones_nxt = ones - BCD_W'(1);
                    end else if (tens != '0) begin
                        ones_nxt = BCD_W'(9);
                        tens_nxt = tens - BCD_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt = ST_RUN;
                    tens_nxt  = LOAD_TENS;
                    ones_nxt  = LOAD_ONES;
                end else if (pause) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_EXPIRED: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt = ST_RUN;
                    tens_nxt  = LOAD_TENS;
                    ones_nxt  = LOAD_ONES;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        secs_nxt = SECS_W'(tens_nxt) * SECS_W'(10) + SECS_W'(ones_nxt);
        warn_nxt = (state_nxt == ST_RUN) && (32'(secs_nxt) <= WARN_SECS);
    end

    // Count and status outputs, all registered from next-state values.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tens    <= LOAD_TENS;
            ones    <= LOAD_ONES;
            running <= 1'b0;
            paused  <= 1'b0;
            expired <= 1'b0;
            timeout <= 1'b0;
            warn    <= 1'b0;
        end else begin
            tens    <= tens_nxt;
            ones    <= ones_nxt;
            running <= (state_nxt == ST_RUN);
            paused  <= (state_nxt == ST_PAUSE);
            expired <= (state_nxt == ST_EXPIRED);
            timeout <= timeout_nxt;
            warn    <= warn_nxt;
        end
    end

endmodule

// File: tb/tb_round_timer.sv
// Scoreboard bench for round_timer: every output change is matched against a queued expectation.
module tb_round_timer;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] o;
        logic       run;
        logic       pau;
        logic       exp;
        logic       to;
        logic       warn;
    } snap_t;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       slow_clk;
    logic       start;
    logic       stop;
    logic       pause;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       paused;
    logic       expired;
    logic       timeout;
    logic       warn;

    int    checks = 0;
    int    errors = 0;
    snap_t q[$];
    snap_t prev;
    int    m_secs;
    bit    m_run;
    bit    m_pau;
    bit    m_exp;
    bit    found;

    always #5 clk_in = ~clk_in;

    round_timer dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .slow_clk (slow_clk),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .tens     (tens),
        .ones     (ones),
        .running  (running),
        .paused   (paused),
        .expired  (expired),
        .timeout  (timeout),
        .warn     (warn)
    );

    function automatic snap_t vec(logic [3:0] t, logic [3:0] o, logic r, logic p,
                                  logic e, logic to, logic w);
        vec = {t, o, r, p, e, to, w};
    endfunction

    // Model snapshot from binary seconds; warn threshold is 5.
    function automatic snap_t mk(int secs, bit r, bit p, bit e, bit to);
        mk = vec(4'(secs / 10), 4'(secs % 10), r, p, e, to, r && (secs <= 5));
    endfunction

    function automatic snap_t sample();
        sample = {tens, ones, running, paused, expired, timeout, warn};
    endfunction

    task automatic push_model(bit to);
        q.push_back(mk(m_secs, m_run, m_pau, m_exp, to));
    endtask

    task automatic monitor_step();
        snap_t cur;
        snap_t e;
        cur = sample();
        if (prev.to) begin
            checks++;
            if (cur.to !== 1'b0) begin
                errors++;
                $display("FAIL timeout_width got %b need 0", cur.to);
            end
        end
        if (cur !== prev) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change got %h", cur);
            end else begin
                e = q.pop_front();
                if (cur !== e) begin
                    errors++;
                    $display("FAIL scoreboard got %h need %h", cur, e);
                end
            end
        end
        prev = cur;
    endtask

    task automatic chk_now(string name, snap_t e);
        snap_t cur;
        cur = sample();
        checks++;
        if (cur !== e) begin
            errors++;
            $display("FAIL %s got %h need %h", name, cur, e);
        end
    endtask

    task automatic pulse_start();
        m_run = 1; m_pau = 0; m_exp = 0; m_secs = 30;
        push_model(0);
        @(negedge clk_in) start = 1'b1;
        @(negedge clk_in) start = 1'b0;
    endtask

    task automatic pulse_pause();
        m_run = !m_run; m_pau = !m_pau;
        push_model(0);
        @(negedge clk_in) pause = 1'b1;
        @(negedge clk_in) pause = 1'b0;
    endtask

    task automatic slow_period();
        if (m_run) begin
            m_secs--;
            if (m_secs == 0) begin
                m_run = 0; m_exp = 1;
                push_model(1);
                push_model(0);
            end else begin
                push_model(0);
            end
        end
        slow_clk = 1'b1;
        repeat (8) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (8) @(negedge clk_in);
    endtask

    initial begin
        rst = 1'b1; slow_clk = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        m_secs = 30; m_run = 0; m_pau = 0; m_exp = 0;
        repeat (3) @(negedge clk_in);
        chk_now("in_reset", vec(4'd3, 4'd0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk_in);
        chk_now("after_reset", vec(4'd3, 4'd0, 0, 0, 0, 0, 0));
        prev = sample();
        fork
            forever begin
                @(negedge clk_in);
                monitor_step();
            end
        join_none

        repeat (5) slow_period();
        chk_now("idle_hold", vec(4'd3, 4'd0, 0, 0, 0, 0, 0));

        pulse_start();
        repeat (3) slow_period();
        chk_now("count_27", vec(4'd2, 4'd7, 1, 0, 0, 0, 0));
        repeat (2) slow_period();
        pulse_pause();
        chk_now("paused_25", vec(4'd2, 4'd5, 0, 1, 0, 0, 0));
        repeat (4) slow_period();
        chk_now("pause_hold_25", vec(4'd2, 4'd5, 0, 1, 0, 0, 0));
        pulse_pause();
        slow_period();
        chk_now("resume_24", vec(4'd2, 4'd4, 1, 0, 0, 0, 0));

        repeat (14) slow_period();
        chk_now("count_10", vec(4'd1, 4'd0, 1, 0, 0, 0, 0));
        slow_period();
        chk_now("borrow_09", vec(4'd0, 4'd9, 1, 0, 0, 0, 0));
        repeat (3) slow_period();
        chk_now("no_warn_06", vec(4'd0, 4'd6, 1, 0, 0, 0, 0));
        slow_period();
        chk_now("warn_05", vec(4'd0, 4'd5, 1, 0, 0, 0, 1));
        repeat (4) slow_period();
        chk_now("warn_01", vec(4'd0, 4'd1, 1, 0, 0, 0, 1));
        slow_period();
        chk_now("expired_00", vec(4'd0, 4'd0, 0, 0, 1, 0, 0));
        repeat (2) slow_period();
        @(negedge clk_in) pause = 1'b1;
        @(negedge clk_in) pause = 1'b0;
        repeat (2) @(negedge clk_in);
        chk_now("expired_hold", vec(4'd0, 4'd0, 0, 0, 1, 0, 0));

        pulse_start();
        @(negedge clk_in);
        chk_now("restart_30", vec(4'd3, 4'd0, 1, 0, 0, 0, 0));
        repeat (17) slow_period();
        chk_now("count_13", vec(4'd1, 4'd3, 1, 0, 0, 0, 0));

        // Land stop in the same cycle as the tick.
        m_run = 0;
        push_model(0);
        slow_clk = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk_in);
            if (dut.tick) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL tick_align got no tick need tick within 12 cycles");
        end
        stop = 1'b1;
        @(negedge clk_in) stop = 1'b0;
        repeat (6) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (8) @(negedge clk_in);
        chk_now("stop_tick_13", vec(4'd1, 4'd3, 0, 0, 0, 0, 0));
        repeat (2) slow_period();
        chk_now("idle_hold_13", vec(4'd1, 4'd3, 0, 0, 0, 0, 0));

        pulse_start();
        repeat (2) slow_period();
        chk_now("count_28", vec(4'd2, 4'd8, 1, 0, 0, 0, 0));
        m_secs = 30; m_run = 0; m_pau = 0; m_exp = 0;
        push_model(0);
        @(negedge clk_in);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        repeat (2) slow_period();
        chk_now("mid_reset", vec(4'd3, 4'd0, 0, 0, 0, 0, 0));

        repeat (10) @(negedge clk_in);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_expect got %0d left need 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
